cpu_cycle_timer: RTL



---
 rtl/cpu_cycle_timer.sv | 93 +++++++++
 1 files changed

// File: rtl/cpu_cycle_timer.sv
// CPU bus-cycle timer. It counts master clocks through each CPU bus cycle and
// pulses cpu_en on the last clock of the cycle. The cycle length (6, 8 or 12
// clocks) comes from the address and MEMSEL, sampled on the first unstalled
// clock of each cycle. While refresh or a DMA halt is active, the cycle in
// progress is frozen.
//
// There is no valid/ready handshake here. cpu_en is a free-running strobe, and
// stall only holds the counter. The phase output exposes the counter state
// directly.
module cpu_cycle_timer #(
    parameter int FAST_LEN  = 6,
    parameter int SLOW_LEN  = 8,
    parameter int XSLOW_LEN = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] addr,
    input  logic        io_cycle,
    input  logic        memsel,
    input  logic        refresh,
    input  logic        halt,
    output logic        cpu_en,
    output logic [3:0]  phase,
    output logic [3:0]  cycle_len,
    output logic        stall
);

    localparam logic [3:0] FAST  = 4'(FAST_LEN);
    localparam logic [3:0] SLOW  = 4'(SLOW_LEN);
    localparam logic [3:0] XSLOW = 4'(XSLOW_LEN);

    logic [3:0] phase_q;
    logic [3:0] len_reg;
    logic [3:0] dec_len;
    logic [7:0] bank;
    logic       terminal;

    // The low nine offset bits never affect the speed map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[8:0];

    assign bank      = addr[23:16];
    assign stall     = refresh | halt;
    assign terminal  = (phase_q == len_reg - 4'd1);
    assign cpu_en    = !stall && terminal;
    assign phase     = phase_q;
    assign cycle_len = len_reg;

    // Speed decode of the upcoming access.
    always_comb begin
        dec_len = SLOW;
        if (io_cycle) begin
            dec_len = FAST;
        end else if (!bank[6]) begin
            // Banks $00-$3F and $80-$BF: the system area is split by offset.
            if (addr[15]) begin
                dec_len = (bank[7] && memsel) ? FAST : SLOW;
            end else begin
                case (addr[14:13])
                    2'b00:   dec_len = SLOW;
                    2'b01:   dec_len = FAST;
                    // $4000-$41FF is the joypad serial port. The rest of
                    // $4000-$5FFF is fast I/O.
                    2'b10:   dec_len = (addr[12:9] == 4'b0000) ? XSLOW : FAST;
                    default: dec_len = SLOW;
                endcase
            end
        end else if (bank[7]) begin
            // Banks $C0-$FF are ROM and follow the fast-ROM bit.
            dec_len = memsel ? FAST : SLOW;
        end
    end

    // Cycle counter.
    // The length is latched at phase 0. A stall holds everything, including
    // the terminal phase, so any pending pulse slips until the stall ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 4'd0;
            len_reg <= SLOW;
        end else if (!stall) begin
            if (phase_q == 4'd0) begin
                len_reg <= dec_len;
                phase_q <= 4'd1;
            end else if (terminal) begin
                phase_q <= 4'd0;
            end else begin
                phase_q <= phase_q + 4'd1;
            end
        end
    end

endmodule
